// File: rtl/div_seq.sv
// div_seq: iterative 32-step restoring radix-2 divider for DIV/DIVU in EX.
// Produces {remainder, quotient} for the HI/LO write path and stalls the
// pipeline until the result is ready. One division in flight at a time.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  output logic [63:0] result,
  output logic        result_valid,
  output logic        stallreq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  counter;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] divisor;
  logic        neg_quo;
  logic        neg_rem;

  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] quo_final;
  logic [31:0] rem_final;

  // Operand magnitudes for signed mode; the divide core is always unsigned.
  always_comb begin
    abs_dividend = opdata1;
    abs_divisor  = opdata2;
    if (signed_div && opdata1[31]) abs_dividend = 32'd0 - opdata1;
    if (signed_div && opdata2[31]) abs_divisor  = 32'd0 - opdata2;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor if it fits, and record the quotient bit.
  // The quotient register doubles as the dividend shift register.
  always_comb begin
    shifted   = {rem, quo[31]};
    diff      = shifted - {1'b0, divisor};
    fits      = ~diff[32];
    rem_next  = fits ? diff[31:0] : shifted[31:0];
    quo_next  = {quo[30:0], fits};
    quo_final = neg_quo ? (32'd0 - quo_next) : quo_next;
    rem_final = neg_rem ? (32'd0 - rem_next) : rem_next;
  end

  // The stall is dropped in END so EX can consume the result, and annul or
  // reset always release the pipeline immediately.
  always_comb begin
    stallreq = start & ~annul & ~rst & (state != S_END);
  end

  // Control FSM plus datapath registers; result and result_valid are
  // registered and only change on state transitions into or out of END.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      counter      <= 5'd0;
      rem          <= 32'd0;
      quo          <= 32'd0;
      divisor      <= 32'd0;
      neg_quo      <= 1'b0;
      neg_rem      <= 1'b0;
      result       <= 64'd0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          result_valid <= 1'b0;
          if (start && !annul) begin
            divisor <= abs_divisor;
            quo     <= abs_dividend;
            rem     <= 32'd0;
            counter <= 5'd0;
            neg_quo <= signed_div & (opdata1[31] ^ opdata2[31]);
            neg_rem <= signed_div & opdata1[31];
            if (opdata2 == 32'd0) begin
              state <= S_DIVZERO;
            end else begin
              state <= S_ON;
            end
          end
        end

        S_ON: begin
          if (annul) begin
            state <= S_IDLE;
          end else begin
            rem     <= rem_next;
            quo     <= quo_next;
            counter <= counter + 5'd1;
            if (counter == 5'd31) begin
              result       <= {rem_final, quo_final};
              result_valid <= 1'b1;
              state        <= S_END;
            end
          end
        end

        S_DIVZERO: begin
          if (annul) begin
            state <= S_IDLE;
          end else begin
            result       <= 64'd0;
            result_valid <= 1'b1;
            state        <= S_END;
          end
        end

        S_END: begin
          if (annul || !start) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: begin
          result_valid <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative 32-step radix-2 divider controller for the EX stage. It executes DIV/DIVU on the two source operands delivered over the ID→EX bus and holds the pipeline through stallreq until the quotient and remainder are ready. The result feeds the HI/LO write path: HI takes the remainder, LO takes the quotient. Only one division is in flight at a time; EX raises start for as long as the divide instruction occupies the stage.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit result.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  divide instruction present in EX; held high until the result is consumed.
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE.
- opdata1  in  32  dividend (rs); sampled with start in IDLE.
- opdata2  in  32  divisor (rt); sampled with start in IDLE.
- annul  in  1  flush; aborts any operation in progress.
- result  out  64  {remainder[63:32], quotient[31:0]}; valid only while result_valid is high.
- result_valid  out  1  registered; high only in state END.
- stallreq  out  1  combinational; pipeline stall request to the stall controller.

## Operation
- States: IDLE, DIVZERO, ON, END. Reset → IDLE; result = 0, result_valid = 0, counter = 0.
- IDLE: start=1 and annul=0: latch operands and signed_div. Divisor = 0 → DIVZERO; otherwise → ON with counter = 0. Otherwise stay in IDLE.
- ON: one restoring shift/subtract step per cycle; counter increments. The step at counter = 31 completes the quotient → END. annul=1 → IDLE; the working registers are discarded and result_valid stays 0.
- DIVZERO: always → END with result = 64'h0. annul=1 → IDLE instead.
- END: result_valid = 1 and result held stable. Stay in END while start=1; start=0 → IDLE next edge, result_valid drops. annul=1 → IDLE.
- Signed mode: divide |dividend| by |divisor| unsigned. Negate the quotient when the operand signs differ. The remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF signed: quotient = 0x80000000 (wraps), remainder = 0. No exception is raised.
- Operands are latched once in IDLE; input changes during ON, DIVZERO or END are ignored.
- start=0 during ON or DIVZERO does not abort; only annul or rst aborts.
- stallreq = start & ~annul & (state ≠ END). It is 0 while rst=1.

## Timing
- t0 is the cycle in which IDLE samples start=1.
- Non-zero divisor: ON spans t0+1 … t0+32; END and result_valid=1 at t0+33. Total latency is 33 cycles, and stallreq is high in t0 … t0+32.
- Zero divisor: DIVZERO at t0+1; END at t0+2, with stallreq high in t0 and t0+1.
- In END, stallreq is 0. EX advances, start falls, and the block returns to IDLE one cycle later.
- Back-to-back divides: a new start is accepted only in IDLE, so the minimum issue interval is the latency plus 1 cycle.
- Reset mid-operation: the next edge forces IDLE; result and result_valid clear.
- annul and start both high in IDLE: annul wins; the operation is not started and stallreq = 0.

## Test plan
- DIVU 100 / 7, start held: stallreq high t0..t0+32; at t0+33 result_valid=1, result = {32'd2, 32'd14}; drop start → result_valid 0 next cycle.
- DIV −7 / 2: result = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2: result = {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Divisor 0: END at t0+2, result = 0, stallreq low from t0+2.
- annul pulse at t0+10: IDLE at t0+11, result_valid never asserts. A fresh DIVU 9/3 then completes in 33 cycles with {0, 3}.
- rst asserted at t0+20: all outputs are 0 next cycle. Operands changed during ON have no effect on the result.
